regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Owns the single write port of the 32x32 register file. After reset it runs a
//  clear sequence writing 0 to x1..x31. It then arbitrates round-robin among
//  NREQ writeback requesters (ALU, load unit, mul/div) using valid/ready, and
//  drives RD/WData/RegWr from registers. Sits between writeback sources and RegFile.
// PARAMETERS
//  NREQ           3   number of writeback requesters (2..8)
//  AW             5   register address width
//  DW             32  data width
//  CLEAR_ON_RESET 1   1: run the x1..x31 zero-fill after reset; 0: skip it
// PORTS
//  Clk       in   1        clock, rising edge
//  Reset     in   1        asynchronous, active-high
//  ReqValid  in   NREQ     requester i has a write pending
//  ReqRd     in   NREQ*AW  dest reg of requester i, slice [i*AW +: AW]
//  ReqData   in   NREQ*DW  write data of requester i, slice [i*DW +: DW]
//  ReqReady  out  NREQ     one-hot grant; transfer = ReqValid[i] & ReqReady[i]
//  RD        out  AW       to RegFile.RD
//  WData     out  DW       to RegFile.WData
//  RegWr     out  1        to RegFile.RegWr
//  WrSrc     out  $clog2(NREQ)  index of requester behind current RegWr (debug)
//  InitDone  out  1        clear sequence finished, arbitration live
// BEHAVIOUR
//  Reset (async): state=S_CLEAR (S_RUN if CLEAR_ON_RESET=0), clr_idx=1, rr_ptr=0;
//   RD=0, WData=0, RegWr=0, WrSrc=0, InitDone=0; ReqReady=0 while Reset high.
//  S_CLEAR: each cycle registers RegWr=1, RD=clr_idx, WData=0, then clr_idx+1;
//   the cycle that issues clr_idx=31 moves to S_RUN. Writes land on edges 1..31
//   after Reset falls. InitDone=1 from edge 32. ReqReady=0 throughout.
//  CLEAR_ON_RESET=0: S_RUN from reset; InitDone=1 from the first edge.
//  S_RUN grant: combinational. Search ReqValid from rr_ptr upward, mod NREQ. The
//   first set bit gets ReqReady; at most one bit is high; none if no valid.
//   ReqReady depends only on ReqValid, rr_ptr and state, never on ReqRd/ReqData.
//  Accept on edge with grant g: RD<=ReqRd[g], WData<=ReqData[g], WrSrc<=g,
//   RegWr<=(ReqRd[g]!=0), rr_ptr<=(g+1) mod NREQ. Latency 1: RegWr high the
//   cycle after transfer; RegFile commits on the following edge.
//  No accept: RegWr<=0; RD/WData/WrSrc hold; rr_ptr holds.
//  Writes to x0 are accepted (ReqReady high) but produce RegWr=0.
//  Requester rules: once ReqValid is high, hold ReqValid/ReqRd/ReqData stable
//   until transfer. Throughput: 1 write/cycle; with all valid, each requester
//   is served at least once every NREQ cycles.
//  Same RD from two requesters in consecutive grants: both commit in grant
//   order; last granted wins. No merging or reordering.
//  Reset mid-operation: in-flight write dropped (RegWr=0 at once), state back to
//   S_CLEAR, clear sequence restarts from x1.
//  ReqValid during S_CLEAR: ignored, not lost; requester keeps valid until served.
// STRUCTURE
//  simple_cpu_pkg: XLEN=32, REG_AW=5, NUM_REGS=32, typedef wr_state_e {S_CLEAR,S_RUN}.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr; output one-hot gnt[N] and
//   binary gnt_idx; combinational. Top holds FSM, clr_idx, rr_ptr, output regs.
// TESTING
//  1 Reset 3 cyc, release -> RegWr=1 for 31 cyc, RD=1..31, WData=0; InitDone=1 at cyc 32.
//  2 Req0 valid RD=5 data=0xDEADBEEF -> ReqReady[0]=1 same cyc; next cyc RegWr=1, RD=5, WData=0xDEADBEEF, WrSrc=0.
//  3 All 3 valid held 6 cyc, rr_ptr=0 -> grant order 0,1,2,0,1,2; one ReqReady per cycle.
//  4 Req1 RD=0 data=0x1234 -> ReqReady[1]=1; next cyc RegWr=0; rr_ptr advances to 2.
//  5 Req2 valid from cycle 5 of the clear sequence -> ReqReady[2]=0 until InitDone=1,
//    then granted on the first S_RUN cycle; zero-fill writes uninterrupted.
//  6 Reset pulse mid-stream with req0 accepted -> RegWr=0 next cyc; InitDone=0; clear restarts at RD=1.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared types and sizes for the simple CPU register-file write path.
//   XLEN     : datapath width
//   REG_AW   : register address width
//   NUM_REGS : architectural register count (x0 is hard-wired zero)
//   wr_state_e : write-port owner state (zero-fill or live arbitration)
package simple_cpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [0:0] {
    S_CLEAR,
    S_RUN
  } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req upward from ptr, wrapping modulo N, and grants the first set bit.
//   req     in   N     request vector
//   ptr     in   IW    highest-priority index for this cycle (must be < N)
//   gnt     out  N     one-hot grant, all zero when no request
//   gnt_idx out  IW    binary index of the granted bit (0 when no request)
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owner of the register file's single write port.
// After reset it zero-fills x1..x31 (optional), then arbitrates round-robin
// among NREQ writeback requesters with valid/ready handshakes. All RegFile-facing
// outputs are registered: a transfer shows up as RegWr one cycle later.
//   Clk, Reset : clock (rising edge), asynchronous active-high reset
//   ReqValid   : per-requester write pending
//   ReqRd      : per-requester destination, slice [i*AW +: AW]
//   ReqData    : per-requester data, slice [i*DW +: DW]
//   ReqReady   : one-hot grant (combinational)
//   RD/WData/RegWr : registered write port to the RegFile
//   WrSrc      : requester index behind the current write (debug)
//   InitDone   : clear sequence finished, arbitration live
module regfile_wr_arbiter
  import simple_cpu_pkg::*;
#(
  parameter int unsigned NREQ           = 3,
  parameter int unsigned AW             = REG_AW,
  parameter int unsigned DW             = XLEN,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          ReqValid,
  input  logic [NREQ*AW-1:0]       ReqRd,
  input  logic [NREQ*DW-1:0]       ReqData,
  output logic [NREQ-1:0]          ReqReady,
  output logic [AW-1:0]            RD,
  output logic [DW-1:0]            WData,
  output logic                     RegWr,
  output logic [$clog2(NREQ)-1:0]  WrSrc,
  output logic                     InitDone
);

  localparam int unsigned IW          = $clog2(NREQ);
  localparam wr_state_e   ResetState  = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
  localparam logic [AW-1:0] LastIdx   = AW'(NUM_REGS - 1);

  wr_state_e     state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          regwr_q, regwr_d;
  logic [IW-1:0] wrsrc_q, wrsrc_d;
  logic          init_done_q, init_done_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            run_ok;
  logic            accept;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req     (ReqValid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are suppressed while Reset is held so no requester sees a
  // handshake that the reset is about to discard.
  assign run_ok   = !Reset && (state_q == S_RUN);
  assign ReqReady = run_ok ? gnt : '0;
  assign accept   = run_ok && (|gnt);
  assign sel_rd   = ReqRd[gnt_idx*AW +: AW];
  assign sel_data = ReqData[gnt_idx*DW +: DW];

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rr_ptr_d    = rr_ptr_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    regwr_d     = 1'b0;
    wrsrc_d     = wrsrc_q;
    // Lags the state by one cycle so it rises after the x31 write is visible.
    init_done_d = (state_q == S_RUN);
    unique case (state_q)
      S_CLEAR: begin
        regwr_d   = 1'b1;
        rd_d      = clr_idx_q;
        wdata_d   = '0;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LastIdx) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          rd_d     = sel_rd;
          wdata_d  = sel_data;
          wrsrc_d  = gnt_idx;
          // x0 writes complete the handshake but never reach the RegFile.
          regwr_d  = (sel_rd != '0);
          rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
      end
      default: begin
        state_d = ResetState;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ResetState;
      clr_idx_q   <= AW'(1);
      rr_ptr_q    <= '0;
      rd_q        <= '0;
      wdata_q     <= '0;
      regwr_q     <= 1'b0;
      wrsrc_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      regwr_q     <= regwr_d;
      wrsrc_q     <= wrsrc_d;
      init_done_q <= init_done_d;
    end
  end

  assign RD       = rd_q;
  assign WData    = wdata_q;
  assign RegWr    = regwr_q;
  assign WrSrc    = wrsrc_q;
  assign InitDone = init_done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (NREQ=3, AW=5, DW=32, clear enabled).
// Inputs change 1 time unit after a rising edge; registered outputs are sampled
// there, the combinational grant 1 unit later.
module tb_regfile_wr_arbiter;

  logic        Clk;
  logic        Reset;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic        regwr;
  logic [1:0]  wrsrc;
  logic        init_done;

  int n_vec;
  int n_err;

  regfile_wr_arbiter #(
    .NREQ           (3),
    .AW             (5),
    .DW             (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (req_valid),
    .ReqRd    (req_rd),
    .ReqData  (req_data),
    .ReqReady (req_ready),
    .RD       (rd),
    .WData    (wdata),
    .RegWr    (regwr),
    .WrSrc    (wrsrc),
    .InitDone (init_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    req_valid = 3'b111;
    repeat (3) @(posedge Clk);
    #1;
    n_vec++; if (regwr !== 1'b0) begin n_err++; $display("FAIL reset_regwr got %b want 0", regwr); end
    n_vec++; if (rd !== 5'd0) begin n_err++; $display("FAIL reset_rd got %0d want 0", rd); end
    n_vec++; if (wdata !== 32'd0) begin n_err++; $display("FAIL reset_wdata got %h want 0", wdata); end
    n_vec++; if (wrsrc !== 2'd0) begin n_err++; $display("FAIL reset_wrsrc got %0d want 0", wrsrc); end
    n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_initdone got %b want 0", init_done); end
    n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got %b want 000", req_ready); end
    req_valid = 3'b000;
    Reset     = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      n_vec++; if (regwr !== 1'b1) begin n_err++; $display("FAIL clr_regwr k=%0d got %b want 1", k, regwr); end
      n_vec++; if (rd !== 5'(k)) begin n_err++; $display("FAIL clr_rd got %0d want %0d", rd, k); end
      n_vec++; if (wdata !== 32'd0) begin n_err++; $display("FAIL clr_wdata k=%0d got %h want 0", k, wdata); end
      n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL clr_initdone k=%0d got %b want 0", k, init_done); end
    end
    step();
    n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL initdone_32 got %b want 1", init_done); end
    n_vec++; if (regwr !== 1'b0) begin n_err++; $display("FAIL idle_regwr_32 got %b want 0", regwr); end
  endtask

  // rr_ptr 0 -> 1
  task automatic test_single();
    req_valid        = 3'b001;
    req_rd[0 +: 5]   = 5'd5;
    req_data[0 +: 32] = 32'hDEADBEEF;
    #1;
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL single_ready got %b want 001", req_ready); end
    step();
    req_valid = 3'b000;
    n_vec++; if (regwr !== 1'b1) begin n_err++; $display("FAIL single_regwr got %b want 1", regwr); end
    n_vec++; if (rd !== 5'd5) begin n_err++; $display("FAIL single_rd got %0d want 5", rd); end
    n_vec++; if (wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wdata got %h want deadbeef", wdata); end
    n_vec++; if (wrsrc !== 2'd0) begin n_err++; $display("FAIL single_wrsrc got %0d want 0", wrsrc); end
    step();
    n_vec++; if (regwr !== 1'b0) begin n_err++; $display("FAIL single_idle got %b want 0", regwr); end
    n_vec++; if (rd !== 5'd5) begin n_err++; $display("FAIL single_rd_hold got %0d want 5", rd); end
  endtask

  // rr_ptr 1 -> 2 (x0 write), then all-valid proves ptr=2, grant 2 -> ptr 0
  task automatic test_x0_write();
    req_valid          = 3'b010;
    req_rd[5 +: 5]     = 5'd0;
    req_data[32 +: 32] = 32'h00001234;
    #1;
    n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL x0_ready got %b want 010", req_ready); end
    step();
    req_valid = 3'b000;
    n_vec++; if (regwr !== 1'b0) begin n_err++; $display("FAIL x0_regwr got %b want 0", regwr); end
    n_vec++; if (wrsrc !== 2'd1) begin n_err++; $display("FAIL x0_wrsrc got %0d want 1", wrsrc); end
    req_valid          = 3'b111;
    req_rd             = {5'd9, 5'd8, 5'd7};
    req_data           = {32'h99, 32'h88, 32'h77};
    #1;
    n_vec++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL ptr_after_x0 got %b want 100", req_ready); end
    step();
    req_valid = 3'b000;
    n_vec++; if (regwr !== 1'b1 || rd !== 5'd9 || wrsrc !== 2'd2 || wdata !== 32'h99) begin
      n_err++;
      $display("FAIL ptr2_write got regwr=%b rd=%0d src=%0d d=%h want 1/9/2/99", regwr, rd, wrsrc, wdata);
    end
  endtask

  // rr_ptr 0 -> 0 after six grants
  task automatic test_round_robin();
    int g;
    req_valid = 3'b111;
    req_rd    = {5'd12, 5'd11, 5'd10};
    req_data  = {32'hA2, 32'hA1, 32'hA0};
    for (int c = 0; c < 6; c++) begin
      g = c % 3;
      #1;
      n_vec++; if (req_ready !== 3'(1 << g)) begin n_err++; $display("FAIL rr_ready c=%0d got %b want %b", c, req_ready, 3'(1 << g)); end
      step();
      n_vec++; if (regwr !== 1'b1 || rd !== 5'(10 + g) || wrsrc !== 2'(g) || wdata !== 32'(32'hA0 + g)) begin
        n_err++;
        $display("FAIL rr_write c=%0d got regwr=%b rd=%0d src=%0d d=%h want 1/%0d/%0d/%h",
                 c, regwr, rd, wrsrc, wdata, 10 + g, g, 32'hA0 + g);
      end
    end
    req_valid = 3'b000;
    step();
  endtask

  // Same destination from req0 then req1: both land, in grant order. ptr 0 -> 2.
  task automatic test_back_to_back();
    req_valid = 3'b011;
    req_rd    = {5'd0, 5'd3, 5'd3};
    req_data  = {32'h0, 32'h2, 32'h1};
    #1;
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL b2b_ready0 got %b want 001", req_ready); end
    step();
    req_valid = 3'b010;
    n_vec++; if (regwr !== 1'b1 || rd !== 5'd3 || wdata !== 32'h1) begin
      n_err++; $display("FAIL b2b_first got regwr=%b rd=%0d d=%h want 1/3/1", regwr, rd, wdata);
    end
    #1;
    n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL b2b_ready1 got %b want 010", req_ready); end
    step();
    req_valid = 3'b000;
    n_vec++; if (regwr !== 1'b1 || rd !== 5'd3 || wdata !== 32'h2 || wrsrc !== 2'd1) begin
      n_err++; $display("FAIL b2b_second got regwr=%b rd=%0d d=%h src=%0d want 1/3/2/1", regwr, rd, wdata, wrsrc);
    end
    step();
  endtask

  // Requester 2 raises valid during the clear; it must wait, then win first.
  task automatic test_clear_pending();
    Reset     = 1'b1;
    req_valid = 3'b000;
    step();
    step();
    Reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      n_vec++; if (regwr !== 1'b1 || rd !== 5'(k) || wdata !== 32'd0) begin
        n_err++; $display("FAIL pend_clr k=%0d got regwr=%b rd=%0d d=%h want 1/%0d/0", k, regwr, rd, wdata, k);
      end
      if (k == 5) begin
        req_valid          = 3'b100;
        req_rd[10 +: 5]    = 5'd20;
        req_data[64 +: 32] = 32'hCAFE0020;
      end
      #1;
      n_vec++; if (req_ready !== ((k == 31) ? 3'b100 : 3'b000)) begin
        n_err++; $display("FAIL pend_ready k=%0d got %b want %b", k, req_ready, (k == 31) ? 3'b100 : 3'b000);
      end
      #1;
    end
    step();
    req_valid = 3'b000;
    n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL pend_initdone got %b want 1", init_done); end
    n_vec++; if (regwr !== 1'b1 || rd !== 5'd20 || wdata !== 32'hCAFE0020 || wrsrc !== 2'd2) begin
      n_err++; $display("FAIL pend_write got regwr=%b rd=%0d d=%h src=%0d want 1/20/cafe0020/2", regwr, rd, wdata, wrsrc);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req_valid         = 3'b001;
    req_rd[0 +: 5]    = 5'd6;
    req_data[0 +: 32] = 32'h66;
    #1;
    n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL mid_ready got %b want 001", req_ready); end
    step();
    n_vec++; if (regwr !== 1'b1 || rd !== 5'd6) begin n_err++; $display("FAIL mid_write got regwr=%b rd=%0d want 1/6", regwr, rd); end
    Reset = 1'b1;
    #1;
    n_vec++; if (regwr !== 1'b0) begin n_err++; $display("FAIL mid_drop got %b want 0", regwr); end
    n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL mid_initdone got %b want 0", init_done); end
    n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL mid_ready_rst got %b want 000", req_ready); end
    req_valid = 3'b000;
    step();
    Reset = 1'b0;
    step();
    n_vec++; if (regwr !== 1'b1 || rd !== 5'd1) begin n_err++; $display("FAIL mid_restart1 got regwr=%b rd=%0d want 1/1", regwr, rd); end
    step();
    n_vec++; if (regwr !== 1'b1 || rd !== 5'd2) begin n_err++; $display("FAIL mid_restart2 got regwr=%b rd=%0d want 1/2", regwr, rd); end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    Reset     = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    #1;
    test_reset();
    test_single();
    test_x0_write();
    test_round_robin();
    test_back_to_back();
    test_clear_pending();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
